avalon_slave_regfile: RTL and testbench

- Synthesizable Avalon-MM slave (responder) containing a bank of DW-bit registers.
- Answers read/write requests from an Avalon-MM master through a waitrequest handshake, with programmable read/write wait states.
- Used as the DUT-side target for Avalon master BFMs and as a generic CSR bank behind an Avalon interconnect.

---
 rtl/avalon_slave_regfile.sv | 175 +++++++++++++++++
 tb/tb_avalon_slave_regfile.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/avalon_slave_regfile.sv
// Avalon-MM responder with a bank of DW-bit registers and programmable wait states.
// Optional macro AVS_BYTEENABLE_EN adds per-byte write enables through a byteenable input.
module avalon_slave_regfile #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 4,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned RD_WAIT  = 2,
    parameter int unsigned WR_WAIT  = 1,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   address,
    input  logic            read,
    input  logic            write,
    input  logic [DW-1:0]   writedata,
`ifdef AVS_BYTEENABLE_EN
    input  logic [DW/8-1:0] byteenable,
`endif
    output logic [DW-1:0]   readdata,
    output logic            waitrequest,
    output logic            addr_err
);

    localparam int unsigned BEW = DW / 8;
    localparam int unsigned CW  = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           op_wr_q, op_wr_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [BEW-1:0] be_q, be_d;
    logic [DW-1:0]  readdata_q, readdata_d;
    logic           addr_err_q, addr_err_d;
    logic           waitrequest_q;
    logic [DW-1:0]  regs_q [NUM_REGS];
    logic [DW-1:0]  rd_reg_c;
    logic [DW-1:0]  wmask_c;
    logic           enter_ack_c;
    logic           wr_commit_c;

    function automatic logic is_mapped(input logic [AW-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // Next-state logic: request capture in IDLE, wait countdown / abort in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            S_IDLE: begin
                addr_d  = address;
                wdata_d = writedata;
                op_wr_d = write;
`ifdef AVS_BYTEENABLE_EN
                be_d    = byteenable;
`else
                be_d    = '1;
`endif
                if (write) begin
                    if (WR_WAIT == 0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(WR_WAIT);
                    end
                end else if (read) begin
                    if (RD_WAIT == 0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(RD_WAIT);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (op_wr_q ? !write : !read) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= CW'(1)) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read mux over implemented registers; unmapped slots never match.
    always_comb begin
        rd_reg_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_d == AW'(i)) begin
                rd_reg_c = regs_q[i];
            end
        end
    end

    always_comb begin
        enter_ack_c = (state_d == S_ACK) && (state_q != S_ACK);
        readdata_d  = readdata_q;
        addr_err_d  = 1'b0;
        if (enter_ack_c) begin
            addr_err_d = !is_mapped(addr_d);
            if (!op_wr_d) begin
                readdata_d = is_mapped(addr_d) ? rd_reg_c : DW'(ERR_DATA);
            end
        end
    end

    always_comb begin
        wmask_c = '0;
        for (int b = 0; b < BEW; b++) begin
            wmask_c[8*b +: 8] = {8{be_q[b]}};
        end
        wr_commit_c = (state_q == S_ACK) && op_wr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_wr_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            readdata_q    <= '0;
            addr_err_q    <= 1'b0;
            waitrequest_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_wr_q       <= op_wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            readdata_q    <= readdata_d;
            addr_err_q    <= addr_err_d;
            waitrequest_q <= (state_d != S_ACK);
        end
    end

    // Register bank: written at the edge that ends ACK, lane-masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_commit_c && (addr_q == AW'(i))) begin
                    regs_q[i] <= (regs_q[i] & ~wmask_c) | (wdata_q & wmask_c);
                end
            end
        end
    end

    assign readdata    = readdata_q;
    assign waitrequest = waitrequest_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_avalon_slave_regfile.sv
// Directed bench for avalon_slave_regfile (NUM_REGS=8, RD_WAIT=2, WR_WAIT=1).
module tb_avalon_slave_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        addr_err;
`ifdef AVS_BYTEENABLE_EN
    logic [3:0]  byteenable = 4'hF;
`endif

    int n_cmp = 0;
    int n_err = 0;

    avalon_slave_regfile #(
        .DW(32), .AW(4), .NUM_REGS(8), .RD_WAIT(2), .WR_WAIT(1), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
`ifdef AVS_BYTEENABLE_EN
        .byteenable(byteenable),
`endif
        .readdata(readdata),
        .waitrequest(waitrequest),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Each transfer task starts and ends #1 after a rising edge, with the FSM back in IDLE.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d,
                            output int lat, output logic err);
        write = 1'b1; address = a; writedata = d; lat = 0; err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (!waitrequest) begin
                lat = k; err = addr_err;
                break;
            end
        end
        write = 1'b0; read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d,
                           output int lat, output logic err);
        read = 1'b1; address = a; lat = 0; err = 1'b0; d = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (!waitrequest) begin
                lat = k; err = addr_err; d = readdata;
                break;
            end
        end
        read = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        logic        err;
        logic [31:0] d;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_waitrequest", 32'(waitrequest), 32'd1);
        check("rst_readdata", readdata, 32'h0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        for (int a = 0; a < 8; a++) begin
            do_read(4'(a), d, lat, err);
            check($sformatf("rst_read_%0d", a), d, 32'h0);
        end

        do_write(4'd3, 32'hA5A5_0001, lat, err);
        check("wr3_latency", 32'(lat), 32'd2);
        check("wr3_addr_err", 32'(err), 32'd0);
        check("post_ack_waitrequest", 32'(waitrequest), 32'd1);
        do_read(4'd3, d, lat, err);
        check("rd3_latency", 32'(lat), 32'd3);
        check("rd3_data", d, 32'hA5A5_0001);
        do_write(4'd2, 32'h0000_0022, lat, err);
        do_write(4'd7, 32'hFFFF_FFFF, lat, err);
        do_read(4'd7, d, lat, err);
        check("rd7_data", d, 32'hFFFF_FFFF);

        do_write(4'd12, 32'h0000_1234, lat, err);
        check("wr12_latency", 32'(lat), 32'd2);
        check("wr12_addr_err", 32'(err), 32'd1);
        check("wr12_err_cleared", 32'(addr_err), 32'd0);
        do_read(4'd4, d, lat, err);
        check("rd4_unchanged", d, 32'h0);
        do_read(4'd3, d, lat, err);
        check("rd3_unchanged", d, 32'hA5A5_0001);
        do_read(4'd12, d, lat, err);
        check("rd12_data", d, 32'hDEAD_BEEF);
        check("rd12_addr_err", 32'(err), 32'd1);
        check("rd12_readdata_hold", readdata, 32'hDEAD_BEEF);

        // Read abort: drop read during WAIT, no ack may follow.
        read = 1'b1; address = 4'd3;
        @(posedge clk); #1;
        check("abort_rd_in_wait", 32'(waitrequest), 32'd1);
        read = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("abort_rd_no_ack_%0d", k), 32'(waitrequest), 32'd1);
        end
        check("abort_rd_readdata", readdata, 32'hDEAD_BEEF);
        do_read(4'd3, d, lat, err);
        check("after_abort_latency", 32'(lat), 32'd3);
        check("after_abort_data", d, 32'hA5A5_0001);

        // Write abort: register must not change.
        write = 1'b1; address = 4'd1; writedata = 32'h1111_1111;
        @(posedge clk); #1;
        write = 1'b0;
        @(posedge clk); #1;
        check("abort_wr_no_ack", 32'(waitrequest), 32'd1);
        do_read(4'd1, d, lat, err);
        check("abort_wr_reg1", d, 32'h0);

        // Simultaneous read+write behaves as a write.
        read = 1'b1;
        do_write(4'd5, 32'h0000_0077, lat, err);
        check("rw5_latency", 32'(lat), 32'd2);
        do_read(4'd5, d, lat, err);
        check("rw5_data", d, 32'h0000_0077);

        // Latched address/data win over changes during WAIT.
        write = 1'b1; address = 4'd6; writedata = 32'h6666_0006;
        @(posedge clk); #1;
        address = 4'd4; writedata = 32'h4444_4444;
        @(posedge clk); #1;
        check("latch_ack", 32'(waitrequest), 32'd0);
        write = 1'b0;
        @(posedge clk); #1;
        do_read(4'd6, d, lat, err);
        check("latch_reg6", d, 32'h6666_0006);
        do_read(4'd4, d, lat, err);
        check("latch_reg4", d, 32'h0);

`ifdef AVS_BYTEENABLE_EN
        byteenable = 4'hF;
        do_write(4'd0, 32'hFFFF_FFFF, lat, err);
        byteenable = 4'b0101;
        do_write(4'd0, 32'h0000_0000, lat, err);
        do_read(4'd0, d, lat, err);
        check("be_0101", d, 32'hFF00_FF00);
        byteenable = 4'b0000;
        do_write(4'd0, 32'h0000_0000, lat, err);
        check("be_none_ack", 32'(lat), 32'd2);
        do_read(4'd0, d, lat, err);
        check("be_none_data", d, 32'hFF00_FF00);
        byteenable = 4'hF;
`endif

        // Reset in the middle of a write to addr 2.
        write = 1'b1; address = 4'd2; writedata = 32'hCAFE_0002;
        @(posedge clk); #1;
        check("rstmid_in_wait", 32'(waitrequest), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_waitrequest", 32'(waitrequest), 32'd1);
        check("rstmid_readdata", readdata, 32'h0);
        write = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        do_read(4'd2, d, lat, err);
        check("rstmid_reg2", d, 32'h0);
        do_read(4'd3, d, lat, err);
        check("rstmid_reg3", d, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
